// File: rtl/mmio_pkg.sv
// -----------------------------------------------------------------------------
// mmio_pkg
//
// Purpose: shared constants and types for the core's memory-mapped I/O
// controller (mmio_ctrl) and its optional RX FIFO (mmio_rx_fifo).
//
// Contents:
//   MMIO_REGION            addr[31:28] code that selects the MMIO region
//   OFF_*                  register offsets, expressed as the addr[6:2] index
//   DEFAULT_COUNTER_WIDTH  default width of the cycle/instruction counters
//   DEFAULT_RX_DEPTH       default RX FIFO depth (MMIO_RX_FIFO_EN builds)
//   tx_state_e             TX slot state; the encoding is visible on trmt_full
//   is_mmio_region()       region decode helper
// -----------------------------------------------------------------------------
package mmio_pkg;

  localparam logic [3:0] MMIO_REGION = 4'b1000;

  // Offsets are word indices taken from addr[6:2].
  localparam logic [4:0] OFF_UART_STAT = 5'h00;  // byte offset 0x00
  localparam logic [4:0] OFF_RX_DATA   = 5'h01;  // byte offset 0x04
  localparam logic [4:0] OFF_TX_DATA   = 5'h02;  // byte offset 0x08
  localparam logic [4:0] OFF_CYC       = 5'h04;  // byte offset 0x10
  localparam logic [4:0] OFF_INST      = 5'h05;  // byte offset 0x14
  localparam logic [4:0] OFF_CNT_RST   = 5'h06;  // byte offset 0x18
  localparam logic [4:0] OFF_BTN_DATA  = 5'h09;  // byte offset 0x24

  localparam int DEFAULT_COUNTER_WIDTH = 32;
  localparam int DEFAULT_RX_DEPTH      = 4;

  // The TX slot state doubles as trmt_full / tx_data_out_valid, so the
  // encoding is deliberately the one-bit "slot occupied" flag.
  typedef enum logic {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_e;

  function automatic logic is_mmio_region(input logic [3:0] region_bits);
    return (region_bits == MMIO_REGION);
  endfunction

endpackage

// File: rtl/mmio_rx_fifo.sv
// -----------------------------------------------------------------------------
// mmio_rx_fifo
//
// Purpose: small synchronous FIFO that buffers bytes from the UART receiver
// when the design is built with MMIO_RX_FIFO_EN. The head entry is shown
// combinationally so a load can return it in the same cycle it pops.
//
// Parameters:
//   DEPTH  number of entries; power of two, >= 2 (pointers wrap naturally)
//   WIDTH  entry width in bits
//
// Ports:
//   clk          input   core clock
//   rst          input   asynchronous, active-high reset
//   i_push       input   write i_push_data at the tail (ignored when full)
//   i_push_data  input   entry to append
//   i_pop        input   drop the head entry (ignored when empty)
//   o_full       output  all DEPTH entries occupied
//   o_empty      output  no entries held
//   o_head       output  oldest entry (stale contents when empty)
//
// A push and a pop in the same cycle leave the count unchanged; the pushed
// entry lands behind the entries that remain.
// -----------------------------------------------------------------------------
module mmio_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  output logic             o_full,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE   = AW'(1);
  localparam logic [AW:0]   CNT_ONE   = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_DEPTH = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_DEPTH);
  assign o_empty = (r_count == '0);
  assign o_head  = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop  & ~o_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // Storage is cleared so the head reads as zero straight out of reset.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mmio_ctrl.sv
// -----------------------------------------------------------------------------
// mmio_ctrl
//
// Purpose: sequential controller for the core's memory-mapped I/O region
// (addr[31:28] == 4'b1000). It decodes memory-stage loads and stores, owns
// the UART TX/RX handshakes, the cycle and retired-instruction counters and
// the button-FIFO pop, and presents the status/data signals that the
// pipeline's load-data select mux returns.
//
// Register map (byte offset, decoded from addr[6:2]):
//   0x00 UART status (read by the load mux)   0x04 RX data (load pops)
//   0x08 TX data (store)                      0x10 cycle counter
//   0x14 instruction counter                  0x18 counter reset (store)
//   0x24 button data (load pops button FIFO)
//
// Build option: define MMIO_RX_FIFO_EN to replace the single RX holding
// register with an RX_DEPTH-entry FIFO (mmio_rx_fifo).
//
// Handshakes: both UART links use strict valid/ready. A byte moves only in a
// cycle where valid and ready are both high; the source holds valid and data
// stable until then, and ready may depend only on the sink's own state.
//
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   addr, wdata          memory-stage byte address and store data
//   we                   store byte mask (any nonzero bit = store)
//   re                   load strobe
//   inst_retire          one instruction retired this cycle
//   tx_data_out(_valid)  byte and valid towards the UART transmitter
//   tx_data_out_ready    transmitter accepts the byte
//   rx_data_in(_valid)   byte and valid from the UART receiver
//   rx_data_in_ready     controller can accept an RX byte
//   buttons_empty        button FIFO empty
//   buttons_rd_en        button FIFO pop (combinational, one per load)
//   trmt_full            TX slot occupied
//   recv_empty           no RX byte held
//   recv_data            oldest held RX byte
//   counter_cycle        free-running cycle counter
//   counter_inst         retired-instruction counter
// -----------------------------------------------------------------------------
module mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int COUNTER_WIDTH = DEFAULT_COUNTER_WIDTH,
  parameter int RX_DEPTH      = DEFAULT_RX_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  input  logic [3:0]               we,
  input  logic                     re,
  input  logic                     inst_retire,
  output logic [7:0]               tx_data_out,
  output logic                     tx_data_out_valid,
  input  logic                     tx_data_out_ready,
  input  logic [7:0]               rx_data_in,
  input  logic                     rx_data_in_valid,
  output logic                     rx_data_in_ready,
  input  logic                     buttons_empty,
  output logic                     buttons_rd_en,
  output logic                     trmt_full,
  output logic                     recv_empty,
  output logic [7:0]               recv_data,
  output logic [COUNTER_WIDTH-1:0] counter_cycle,
  output logic [COUNTER_WIDTH-1:0] counter_inst
);

  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = COUNTER_WIDTH'(1);

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [4:0] w_off;
  logic       w_hit;
  logic       w_store;
  logic       w_load;
  logic       w_tx_wr;
  logic       w_cnt_clr;
  logic       w_rx_rd;
  logic       w_btn_rd;
  logic       w_plain_load;

  assign w_off        = addr[6:2];
  assign w_hit        = is_mmio_region(addr[31:28]);
  assign w_store      = w_hit & (|we);
  assign w_load       = w_hit & re;
  assign w_tx_wr      = w_store & (w_off == OFF_TX_DATA);
  assign w_cnt_clr    = w_store & (w_off == OFF_CNT_RST);
  assign w_rx_rd      = w_load  & (w_off == OFF_RX_DATA);
  assign w_btn_rd     = w_load  & (w_off == OFF_BTN_DATA);
  // Status and counter reads are served entirely by the external load mux;
  // they have no side effect here.
  assign w_plain_load = w_load & ((w_off == OFF_UART_STAT) |
                                  (w_off == OFF_CYC) |
                                  (w_off == OFF_INST));

  // Address bits outside the decode, upper store-data bits and side-effect
  // free reads are intentionally ignored by this block.
  logic w_unused;
  assign w_unused = ^{addr[27:7], addr[1:0], wdata[31:8], w_plain_load};

  // ---------------------------------------------------------------------------
  // TX slot: one-entry buffer, two-process FSM
  // ---------------------------------------------------------------------------
  tx_state_e  r_tx_state;
  tx_state_e  w_tx_state_nxt;
  logic [7:0] r_tx_data;
  logic [7:0] w_tx_data_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_state <= TX_EMPTY;
      r_tx_data  <= 8'h00;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      r_tx_data  <= w_tx_data_nxt;
    end
  end

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_data_nxt  = r_tx_data;
    case (r_tx_state)
      TX_EMPTY: begin
        if (w_tx_wr) begin
          w_tx_state_nxt = TX_FULL;
          w_tx_data_nxt  = wdata[7:0];
        end
      end
      TX_FULL: begin
        // Any store while occupied is dropped, including one in the very
        // cycle the transmitter takes the byte: software polls status first.
        if (tx_data_out_ready) begin
          w_tx_state_nxt = TX_EMPTY;
        end
      end
    endcase
  end

  assign tx_data_out       = r_tx_data;
  assign tx_data_out_valid = (r_tx_state == TX_FULL);
  assign trmt_full         = (r_tx_state == TX_FULL);

  // ---------------------------------------------------------------------------
  // RX path
  // ---------------------------------------------------------------------------
`ifdef MMIO_RX_FIFO_EN
  logic       w_rx_full;
  logic       w_rx_empty;
  logic [7:0] w_rx_head;
  logic       w_rx_push;
  logic       w_rx_pop;

  assign w_rx_push = rx_data_in_valid & ~w_rx_full;
  assign w_rx_pop  = w_rx_rd & ~w_rx_empty;

  mmio_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_rx_push),
    .i_push_data (rx_data_in),
    .i_pop       (w_rx_pop),
    .o_full      (w_rx_full),
    .o_empty     (w_rx_empty),
    .o_head      (w_rx_head)
  );

  assign rx_data_in_ready = ~w_rx_full;
  assign recv_empty       = w_rx_empty;
  assign recv_data        = w_rx_head;
`else
  logic       r_recv_empty;
  logic [7:0] r_recv_data;
  logic       w_rx_push;
  logic       w_rx_pop;

  // Push needs an empty register and pop needs a full one, so the two
  // never coincide.
  assign w_rx_push = rx_data_in_valid & r_recv_empty;
  assign w_rx_pop  = w_rx_rd & ~r_recv_empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_recv_empty <= 1'b1;
      r_recv_data  <= 8'h00;
    end else if (w_rx_push) begin
      r_recv_empty <= 1'b0;
      r_recv_data  <= rx_data_in;
    end else if (w_rx_pop) begin
      // The byte stays in r_recv_data; only the occupancy flag drops, so the
      // load mux still returns it during the pop cycle.
      r_recv_empty <= 1'b1;
    end
  end

  assign rx_data_in_ready = r_recv_empty;
  assign recv_empty       = r_recv_empty;
  assign recv_data        = r_recv_data;

  // The FIFO depth only matters in MMIO_RX_FIFO_EN builds.
  logic w_unused_rx_depth;
  assign w_unused_rx_depth = (RX_DEPTH >= 2);
`endif

  // ---------------------------------------------------------------------------
  // Cycle and retired-instruction counters (wrap modulo 2^COUNTER_WIDTH)
  // ---------------------------------------------------------------------------
  logic [COUNTER_WIDTH-1:0] r_cnt_cycle;
  logic [COUNTER_WIDTH-1:0] r_cnt_inst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt_cycle <= '0;
      r_cnt_inst  <= '0;
    end else if (w_cnt_clr) begin
      // Clear beats the increment of the same cycle.
      r_cnt_cycle <= '0;
      r_cnt_inst  <= '0;
    end else begin
      r_cnt_cycle <= r_cnt_cycle + CNT_ONE;
      if (inst_retire) begin
        r_cnt_inst <= r_cnt_inst + CNT_ONE;
      end
    end
  end

  assign counter_cycle = r_cnt_cycle;
  assign counter_inst  = r_cnt_inst;

  // ---------------------------------------------------------------------------
  // Button FIFO pop: combinational, one pop per qualified load
  // ---------------------------------------------------------------------------
  assign buttons_rd_en = w_btn_rd & ~buttons_empty;

endmodule
